// File: rtl/pipeline_mem_pkg.sv
// Shared types and encodings for the MEM pipeline stage: FSM states, funct3 access
// codes, write-back select codes and the alignment/strobe helpers.
package pipeline_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  localparam logic [1:0] WB_SEL_ZERO = 2'b00;
  localparam logic [1:0] WB_SEL_PC4  = 2'b01;
  localparam logic [1:0] WB_SEL_ALU  = 2'b10;
  localparam logic [1:0] WB_SEL_MEM  = 2'b11;

  // Natural alignment test; the same table serves loads and stores.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] lo);
    logic r;
    case (f3)
      3'b001, 3'b101: r = lo[0];
      3'b010, 3'b110: r = |lo[1:0];
      3'b011:         r = |lo;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

  // Byte enables for a store; lanes shifted past byte 7 fall off the 8-bit result.
  function automatic logic [7:0] store_strobe(input logic [2:0] f3, input logic [2:0] lo);
    logic [7:0] base;
    case (f3[1:0])
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      2'b10:   base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lo;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load data lane selection and sign/zero extension, purely combinational.
module mem_load_ext
  import pipeline_mem_pkg::*;
(
  input  logic [63:0] i_rdata,
  input  logic [2:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [63:0] o_data
);

  logic [63:0] w_lane;

  assign w_lane = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_LB:   o_data = {{56{w_lane[7]}},  w_lane[7:0]};
      F3_LH:   o_data = {{48{w_lane[15]}}, w_lane[15:0]};
      F3_LW:   o_data = {{32{w_lane[31]}}, w_lane[31:0]};
      F3_LD:   o_data = w_lane;
      F3_LBU:  o_data = {56'd0, w_lane[7:0]};
      F3_LHU:  o_data = {48'd0, w_lane[15:0]};
      F3_LWU:  o_data = {32'd0, w_lane[31:0]};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/pipeline_mem_stage.sv
// MEM pipeline stage: single outstanding memory request with IDLE/BUSY/DONE FSM.
// Build option: MEM_MISALIGN_CHECK_EN turns misaligned accesses into flagged pass-throughs.
module pipeline_mem_stage
  import pipeline_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        valid_EX,
  input  logic [63:0] alu_result_EX,
  input  logic [63:0] store_data_EX,
  input  logic [4:0]  rd_EX,
  input  logic        reg_write_EX,
  input  logic [1:0]  rf_wr_sel_EX,
  input  logic        mem_read_EX,
  input  logic        mem_write_EX,
  input  logic [2:0]  funct3_EX,
  input  logic [63:0] pc_EX,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        valid_MEM,
  output logic [63:0] alu_result_MEM,
  output logic [63:0] mem_data_MEM,
  output logic [4:0]  rd_MEM,
  output logic        reg_write_MEM,
  output logic [1:0]  rf_wr_sel,
  output logic [63:0] pc_WB,
  output logic        misalign_MEM,
  output logic        stall_req
);

  mem_state_e  r_state;

  logic [63:0] r_req_addr;
  logic [63:0] r_req_wdata;
  logic [7:0]  r_req_wstrb;
  logic        r_req_we;
  logic        r_req_load;
  logic [2:0]  r_req_funct3;
  logic [4:0]  r_req_rd;
  logic        r_req_reg_write;
  logic [1:0]  r_req_sel;
  logic [63:0] r_req_pc;
  logic [63:0] r_rdata_buf;

  logic        r_valid;
  logic [63:0] r_alu;
  logic [63:0] r_mdata;
  logic [4:0]  r_rd;
  logic        r_reg_write;
  logic [1:0]  r_sel;
  logic [63:0] r_pc;
  logic        r_misalign;

  logic        w_is_mem;
  logic        w_misalign_ex;
  logic        w_idle;
  logic        w_accept;
  logic        w_pass;
  logic        w_retire;
  logic        w_to_done;
  logic        w_bubble;
  logic [63:0] w_ld_src;
  logic [63:0] w_ld_ext;
  logic [63:0] w_ret_data;

  assign w_is_mem = mem_read_EX | mem_write_EX;

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_misalign_ex = valid_EX & w_is_mem & is_misaligned(funct3_EX, alu_result_EX[2:0]);
`else
  assign w_misalign_ex = 1'b0;
`endif

  assign w_idle    = (r_state == ST_IDLE);
  assign w_accept  = w_idle & ~stall_in & valid_EX & w_is_mem & ~w_misalign_ex;
  assign w_pass    = w_idle & ~stall_in & valid_EX & ~(w_is_mem & ~w_misalign_ex);
  assign w_retire  = ~stall_in & (((r_state == ST_BUSY) & mem_ack) | (r_state == ST_DONE));
  assign w_to_done = stall_in & (r_state == ST_BUSY) & mem_ack;
  // Every free cycle that delivers nothing new clears the WB write, so WB never repeats one.
  assign w_bubble  = ~stall_in & ~w_pass & ~w_retire;

  assign w_ld_src = (r_state == ST_DONE) ? r_rdata_buf : mem_rdata;

  mem_load_ext u_load_ext (
    .i_rdata   (w_ld_src),
    .i_addr_lo (r_req_addr[2:0]),
    .i_funct3  (r_req_funct3),
    .o_data    (w_ld_ext)
  );

  assign w_ret_data = r_req_load ? w_ld_ext : 64'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_req_addr      <= '0;
      r_req_wdata     <= '0;
      r_req_wstrb     <= '0;
      r_req_we        <= 1'b0;
      r_req_load      <= 1'b0;
      r_req_funct3    <= '0;
      r_req_rd        <= '0;
      r_req_reg_write <= 1'b0;
      r_req_sel       <= '0;
      r_req_pc        <= '0;
      r_rdata_buf     <= '0;
    end else if (w_accept) begin
      r_state         <= ST_BUSY;
      r_req_addr      <= alu_result_EX;
      r_req_wdata     <= store_data_EX << {alu_result_EX[2:0], 3'b000};
      r_req_wstrb     <= mem_write_EX ? store_strobe(funct3_EX, alu_result_EX[2:0]) : 8'h00;
      r_req_we        <= mem_write_EX;
      r_req_load      <= mem_read_EX & ~mem_write_EX;
      r_req_funct3    <= funct3_EX;
      r_req_rd        <= rd_EX;
      r_req_reg_write <= reg_write_EX;
      r_req_sel       <= rf_wr_sel_EX;
      r_req_pc        <= pc_EX;
    end else if (w_to_done) begin
      r_state         <= ST_DONE;
      r_rdata_buf     <= mem_rdata;
    end else if (w_retire) begin
      r_state         <= ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_alu       <= '0;
      r_mdata     <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_sel       <= '0;
      r_pc        <= '0;
      r_misalign  <= 1'b0;
    end else if (w_pass) begin
      r_valid     <= 1'b1;
      r_alu       <= alu_result_EX;
      r_mdata     <= 64'd0;
      r_rd        <= rd_EX;
      r_reg_write <= reg_write_EX & ~w_misalign_ex;
      r_sel       <= rf_wr_sel_EX;
      r_pc        <= pc_EX;
      r_misalign  <= w_misalign_ex;
    end else if (w_retire) begin
      r_valid     <= 1'b1;
      r_alu       <= r_req_addr;
      r_mdata     <= w_ret_data;
      r_rd        <= r_req_rd;
      r_reg_write <= r_req_reg_write;
      r_sel       <= r_req_sel;
      r_pc        <= r_req_pc;
      r_misalign  <= 1'b0;
    end else if (w_bubble) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_misalign  <= 1'b0;
    end
  end

  assign mem_req   = (r_state == ST_BUSY);
  assign mem_we    = mem_req & r_req_we;
  assign mem_addr  = {r_req_addr[63:3], 3'b000};
  assign mem_wdata = r_req_wdata;
  assign mem_wstrb = r_req_wstrb;

  assign stall_req = ~w_idle | stall_in;

  assign valid_MEM      = r_valid;
  assign alu_result_MEM = r_alu;
  assign mem_data_MEM   = r_mdata;
  assign rd_MEM         = r_rd;
  assign reg_write_MEM  = r_reg_write;
  assign rf_wr_sel      = r_sel;
  assign pc_WB          = r_pc;
  assign misalign_MEM   = r_misalign;

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Directed bench for pipeline_mem_stage with a write-back scoreboard queue.
// Honors MEM_MISALIGN_CHECK_EN to pick the matching misalignment expectations.
module tb_pipeline_mem_stage;

  logic        clk;
  logic        reset;
  logic        stall_in;
  logic        valid_EX;
  logic [63:0] alu_result_EX;
  logic [63:0] store_data_EX;
  logic [4:0]  rd_EX;
  logic        reg_write_EX;
  logic [1:0]  rf_wr_sel_EX;
  logic        mem_read_EX;
  logic        mem_write_EX;
  logic [2:0]  funct3_EX;
  logic [63:0] pc_EX;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        valid_MEM;
  logic [63:0] alu_result_MEM;
  logic [63:0] mem_data_MEM;
  logic [4:0]  rd_MEM;
  logic        reg_write_MEM;
  logic [1:0]  rf_wr_sel;
  logic [63:0] pc_WB;
  logic        misalign_MEM;
  logic        stall_req;

  typedef struct {
    logic [63:0] alu;
    logic [63:0] mdata;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  sel;
    logic [63:0] pc;
    logic        mis;
  } wb_t;

  wb_t q_exp[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  pipeline_mem_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall_in       (stall_in),
    .valid_EX       (valid_EX),
    .alu_result_EX  (alu_result_EX),
    .store_data_EX  (store_data_EX),
    .rd_EX          (rd_EX),
    .reg_write_EX   (reg_write_EX),
    .rf_wr_sel_EX   (rf_wr_sel_EX),
    .mem_read_EX    (mem_read_EX),
    .mem_write_EX   (mem_write_EX),
    .funct3_EX      (funct3_EX),
    .pc_EX          (pc_EX),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .valid_MEM      (valid_MEM),
    .alu_result_MEM (alu_result_MEM),
    .mem_data_MEM   (mem_data_MEM),
    .rd_MEM         (rd_MEM),
    .reg_write_MEM  (reg_write_MEM),
    .rf_wr_sel      (rf_wr_sel),
    .pc_WB          (pc_WB),
    .misalign_MEM   (misalign_MEM),
    .stall_req      (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle so outputs are sampled away from the clock edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic mr, input logic mw, input logic [2:0] f3,
                          input logic [63:0] alu, input logic [63:0] sd, input logic [4:0] rd,
                          input logic rw, input logic [1:0] sel, input logic [63:0] pc);
    valid_EX      = 1'b1;
    mem_read_EX   = mr;
    mem_write_EX  = mw;
    funct3_EX     = f3;
    alu_result_EX = alu;
    store_data_EX = sd;
    rd_EX         = rd;
    reg_write_EX  = rw;
    rf_wr_sel_EX  = sel;
    pc_EX         = pc;
  endtask

  task automatic clear_ex();
    valid_EX     = 1'b0;
    mem_read_EX  = 1'b0;
    mem_write_EX = 1'b0;
  endtask

  task automatic push_exp(input logic [63:0] alu, input logic [63:0] mdata, input logic [4:0] rd,
                          input logic rw, input logic [1:0] sel, input logic [63:0] pc,
                          input logic mis);
    wb_t e;
    e.alu = alu; e.mdata = mdata; e.rd = rd; e.rw = rw; e.sel = sel; e.pc = pc; e.mis = mis;
    q_exp.push_back(e);
  endtask

  // Pop the oldest expected write-back and compare it with the current outputs.
  task automatic expect_wb(input string tag);
    wb_t e;
    n_cmp++;
    assert (q_exp.size() > 0) else begin
      n_fail++;
      $error("FAIL %s_queue: observed=empty expected=entry", tag);
    end
    if (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      check({tag, "_valid"}, valid_MEM, 1'b1);
      check({tag, "_alu"},   alu_result_MEM, e.alu);
      check({tag, "_mdata"}, mem_data_MEM, e.mdata);
      check({tag, "_rd"},    rd_MEM, e.rd);
      check({tag, "_rw"},    reg_write_MEM, e.rw);
      check({tag, "_sel"},   rf_wr_sel, e.sel);
      check({tag, "_pc"},    pc_WB, e.pc);
      check({tag, "_mis"},   misalign_MEM, e.mis);
      $display("txn %s: alu=%h mdata=%h rd=%0d rw=%0b mis=%0b", tag, alu_result_MEM,
               mem_data_MEM, rd_MEM, reg_write_MEM, misalign_MEM);
    end
  endtask

  initial begin
    int stall_cnt;
    int pulses;

    reset = 1'b1; stall_in = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    valid_EX = 1'b0; alu_result_EX = '0; store_data_EX = '0; rd_EX = '0;
    reg_write_EX = 1'b0; rf_wr_sel_EX = '0; mem_read_EX = 1'b0; mem_write_EX = 1'b0;
    funct3_EX = '0; pc_EX = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_valid", valid_MEM, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_stall_req", stall_req, 1'b0);
    check("rst_alu", alu_result_MEM, 64'd0);
    check("rst_pc", pc_WB, 64'd0);

    // ALU op: one-cycle pass-through.
    drive_ex(1'b0, 1'b0, 3'b000, 64'h1234, 64'd0, 5'd5, 1'b1, 2'b10, 64'h100);
    push_exp(64'h1234, 64'd0, 5'd5, 1'b1, 2'b10, 64'h100, 1'b0);
    tick();
    clear_ex();
    expect_wb("add");

    // Stall in IDLE: nothing accepted, outputs frozen, then accepted on release.
    stall_in = 1'b1;
    drive_ex(1'b0, 1'b0, 3'b000, 64'h55, 64'd0, 5'd3, 1'b1, 2'b10, 64'h104);
    push_exp(64'h55, 64'd0, 5'd3, 1'b1, 2'b10, 64'h104, 1'b0);
    tick();
    check("idle_stall_alu", alu_result_MEM, 64'h1234);
    check("idle_stall_valid", valid_MEM, 1'b1);
    check("idle_stall_req", stall_req, 1'b1);
    stall_in = 1'b0;
    tick();
    clear_ex();
    expect_wb("sub");

    // LB at 0x1003, ack in the third BUSY cycle.
    drive_ex(1'b1, 1'b0, 3'b000, 64'h1003, 64'd0, 5'd7, 1'b1, 2'b11, 64'h108);
    push_exp(64'h1003, 64'hFFFF_FFFF_FFFF_FF80, 5'd7, 1'b1, 2'b11, 64'h108, 1'b0);
    tick();
    clear_ex();
    check("lb_bubble", valid_MEM, 1'b0);
    check("lb_addr", mem_addr, 64'h1000);
    check("lb_we", mem_we, 1'b0);
    stall_cnt = 0;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      if (stall_req) stall_cnt++;
      if (valid_MEM) pulses++;
      check("lb_busy_req", mem_req, 1'b1);
      if (c == 2) begin
        mem_ack = 1'b1;
        mem_rdata = 64'h0000_0000_8000_0000;
      end
      tick();
    end
    mem_ack = 1'b0;
    mem_rdata = '0;
    if (valid_MEM) pulses++;
    expect_wb("lb");
    if (stall_req) stall_cnt++;
    tick();
    if (valid_MEM) pulses++;
    check("lb_stall_cycles", stall_cnt, 3);
    check("lb_pulses", pulses, 1);

    // SH at 0x2006.
    drive_ex(1'b0, 1'b1, 3'b001, 64'h2006, 64'hABCD, 5'd0, 1'b0, 2'b00, 64'h10C);
    push_exp(64'h2006, 64'd0, 5'd0, 1'b0, 2'b00, 64'h10C, 1'b0);
    tick();
    clear_ex();
    check("sh_req", mem_req, 1'b1);
    check("sh_we", mem_we, 1'b1);
    check("sh_wstrb", mem_wstrb, 8'hC0);
    check("sh_wdata_hi", mem_wdata[63:48], 16'hABCD);
    check("sh_addr", mem_addr, 64'h2000);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    expect_wb("sh");

    // SD at 0x10: full strobe, unshifted data.
    drive_ex(1'b0, 1'b1, 3'b011, 64'h10, 64'h0123_4567_89AB_CDEF, 5'd0, 1'b0, 2'b00, 64'h110);
    push_exp(64'h10, 64'd0, 5'd0, 1'b0, 2'b00, 64'h110, 1'b0);
    tick();
    clear_ex();
    check("sd_wstrb", mem_wstrb, 8'hFF);
    check("sd_wdata", mem_wdata, 64'h0123_4567_89AB_CDEF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    expect_wb("sd");

    // LWU at 0x4004 acked under stall: data parked in DONE, retired after release.
    drive_ex(1'b1, 1'b0, 3'b110, 64'h4004, 64'd0, 5'd9, 1'b1, 2'b11, 64'h114);
    push_exp(64'h4004, 64'h0000_0000_89AB_CDEF, 5'd9, 1'b1, 2'b11, 64'h114, 1'b0);
    tick();
    clear_ex();
    mem_ack = 1'b1;
    mem_rdata = 64'h89AB_CDEF_0123_4567;
    stall_in = 1'b1;
    tick();
    mem_ack = 1'b0;
    mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    check("lwu_done_req", mem_req, 1'b0);
    check("lwu_done_stall_req", stall_req, 1'b1);
    check("lwu_done_valid", valid_MEM, 1'b0);
    tick();
    check("lwu_hold_req", mem_req, 1'b0);
    check("lwu_hold_valid", valid_MEM, 1'b0);
    stall_in = 1'b0;
    tick();
    mem_rdata = '0;
    expect_wb("lwu");
    tick();
    check("lwu_after_valid", valid_MEM, 1'b0);

    // Reset mid-BUSY abandons the transaction; a late ack is ignored.
    drive_ex(1'b1, 1'b0, 3'b011, 64'h5000, 64'd0, 5'd11, 1'b1, 2'b11, 64'h118);
    tick();
    clear_ex();
    check("rstbusy_req_before", mem_req, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstbusy_req", mem_req, 1'b0);
    check("rstbusy_stall_req", stall_req, 1'b0);
    check("rstbusy_valid", valid_MEM, 1'b0);
    check("rstbusy_alu", alu_result_MEM, 64'd0);
    check("rstbusy_rd", rd_MEM, 5'd0);
    check("rstbusy_pc", pc_WB, 64'd0);
    mem_ack = 1'b1;
    mem_rdata = 64'h1111_2222_3333_4444;
    tick();
    mem_ack = 1'b0;
    check("stray_ack_valid", valid_MEM, 1'b0);
    check("stray_ack_req", mem_req, 1'b0);
    check("stray_ack_mdata", mem_data_MEM, 64'd0);

`ifdef MEM_MISALIGN_CHECK_EN
    // Misaligned LD: no request, flagged pass-through.
    drive_ex(1'b1, 1'b0, 3'b011, 64'h3004, 64'd0, 5'd12, 1'b1, 2'b11, 64'h11C);
    push_exp(64'h3004, 64'd0, 5'd12, 1'b0, 2'b11, 64'h11C, 1'b1);
    tick();
    clear_ex();
    check("mis_ld_req", mem_req, 1'b0);
    check("mis_ld_stall_req", stall_req, 1'b0);
    expect_wb("mis_ld");
`else
    // Without the check a misaligned LD still issues and reads the shifted lane.
    drive_ex(1'b1, 1'b0, 3'b011, 64'h3004, 64'd0, 5'd12, 1'b1, 2'b11, 64'h11C);
    push_exp(64'h3004, 64'h0000_0000_1122_3344, 5'd12, 1'b1, 2'b11, 64'h11C, 1'b0);
    tick();
    clear_ex();
    check("mis_ld_req", mem_req, 1'b1);
    check("mis_ld_addr", mem_addr, 64'h3000);
    mem_ack = 1'b1;
    mem_rdata = 64'h1122_3344_5566_7788;
    tick();
    mem_ack = 1'b0;
    expect_wb("mis_ld");

    // SH at lane 7: upper strobe bit drops off.
    drive_ex(1'b0, 1'b1, 3'b001, 64'h2007, 64'hABCD, 5'd0, 1'b0, 2'b00, 64'h120);
    push_exp(64'h2007, 64'd0, 5'd0, 1'b0, 2'b00, 64'h120, 1'b0);
    tick();
    clear_ex();
    check("sh7_wstrb", mem_wstrb, 8'h80);
    check("sh7_wdata_hi", mem_wdata[63:56], 8'hCD);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    expect_wb("sh7");
`endif

    tick();
    check("final_queue_empty", q_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_mem_stage.md
PIPELINE_MEM_STAGE -- requirements
Module: pipeline_mem_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
REQ-002 SHALL have these EX-side inputs.
- stall_in  in  1  downstream/global hold.
- valid_EX  in  1  EX slot holds an instruction.
- alu_result_EX  in  64  result or effective address.
- store_data_EX  in  64  rs2 value.
- rd_EX  in  5  destination register.
- reg_write_EX  in  1  register write enable.
- rf_wr_sel_EX  in  2  write-back select, passed through.
- mem_read_EX / mem_write_EX  in  1 each  load / store.
- funct3_EX  in  3  access size and sign.
- pc_EX  in  64  instruction PC.
REQ-003 SHALL have these memory-side ports.
- mem_req  out  1  request.
- mem_we  out  1  write.
- mem_addr  out  64  {addr[63:3],3'b000}.
- mem_wdata  out  64  lane-shifted store data.
- mem_wstrb  out  8  byte enables.
- mem_ack  in  1  completion.
- mem_rdata  in  64  read data.
REQ-004 SHALL have these WB-side outputs, all registered.
- valid_MEM  out  1.
- alu_result_MEM  out  64.
- mem_data_MEM  out  64.
- rd_MEM  out  5.
- reg_write_MEM  out  1.
- rf_wr_sel  out  2.
- pc_WB  out  64.
- misalign_MEM  out  1.
REQ-005 SHALL provide stall_req  out  1: holds EX/upstream; equals (state!=IDLE) | stall_in.

Function
REQ-006 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-007 IDLE, stall_in=0, valid non-memory instruction: SHALL load outputs from EX fields next edge; latency 1 cycle; mem_data_MEM=0.
REQ-008 IDLE, stall_in=0, valid load/store: SHALL capture all EX fields and store_data into a request register, go BUSY, and load a bubble into outputs.
REQ-009 Bubble SHALL mean valid_MEM=0, reg_write_MEM=0, misalign_MEM=0, other outputs unchanged.
REQ-010 Any non-stalled cycle with no retirement and no pass-through SHALL load a bubble, so WB never double-writes.
REQ-011 BUSY: mem_req=1, with mem_we/mem_addr/mem_wdata/mem_wstrb driven from the request register and held stable until mem_ack.
REQ-012 BUSY with mem_ack and stall_in=0: SHALL retire captured fields with extended load data into outputs and return to IDLE.
REQ-013 BUSY with mem_ack and stall_in=1: SHALL latch mem_rdata into a buffer, go DONE, and deassert mem_req.
REQ-014 DONE with stall_in=0: SHALL retire from the buffer and go IDLE; DONE with stall_in=1: SHALL hold.
REQ-015 stall_in=1 in any state SHALL freeze the output register; IDLE SHALL accept nothing.
REQ-016 mem_ack outside BUSY SHALL be ignored.
REQ-017 Load extension by funct3, lane selected by addr[2:0]: 000 LB sign, 001 LH sign, 010 LW sign, 011 LD, 100 LBU, 101 LHU, 110 LWU zero-extend, 111 yields 0.
REQ-018 Store strobes: SB 1 bit, SH 2 bits, SW 4 bits, SD 8'hFF, each shifted left by addr[2:0]; data shifted left by 8*addr[2:0]; strobe bits beyond lane 7 dropped.
REQ-019 mem_we=1 for stores; a store's mem_data_MEM SHALL be 0.
REQ-020 Memory latency SHALL be unbounded; minimum is accept at N, mem_req at N+1, mem_ack at N+1, outputs valid at N+2.

Reset
REQ-021 reset SHALL force IDLE, mem_req=0, all outputs and internal registers to 0 on the next edge, including mid-BUSY or DONE; an outstanding transaction SHALL be abandoned.

Configuration
REQ-022 With MEM_MISALIGN_CHECK_EN defined, the following SHALL apply.
- A load/store with LH/SH addr[0]!=0, LW/LWU/SW addr[1:0]!=0, or LD/SD addr[2:0]!=0 SHALL issue no request.
- It SHALL pass through in 1 cycle with reg_write_MEM=0 and misalign_MEM=1.
REQ-023 Without MEM_MISALIGN_CHECK_EN, misalign_MEM SHALL be tied 0, and misaligned accesses SHALL proceed per REQ-017/018.

Structure
REQ-024 Package pipeline_mem_pkg SHALL hold the FSM state enum, funct3 load/store encodings, and rf_wr_sel codes (00 zero, 01 PC+4, 10 ALU, 11 memory).
REQ-025 Sub-module mem_load_ext SHALL implement REQ-017 combinationally.

Verification
REQ-026 The bench SHALL cover these scenarios.
- ADD, alu_result_EX=0x1234, rd=5 -> next cycle valid_MEM=1, alu_result_MEM=0x1234, rd_MEM=5, reg_write_MEM=1.
- LB at addr 0x1003, mem_rdata=0x00000000_80000000, ack after 3 BUSY cycles -> stall_req high 3 cycles, mem_data_MEM=0xFFFFFFFF_FFFFFF80, exactly one valid_MEM pulse.
- SH at addr 0x2006, data 0xABCD -> mem_wstrb=8'hC0, mem_wdata[63:48]=0xABCD, mem_we=1, reg_write_MEM=0.
- LWU ack with stall_in=1 for 2 cycles -> DONE held, mem_req low, data retired once stall_in falls.
- reset asserted in BUSY -> next cycle mem_req=0, outputs 0, IDLE.
- With MEM_MISALIGN_CHECK_EN: LD at 0x3004 -> no mem_req, misalign_MEM=1, reg_write_MEM=0.
